// File: rtl/lsu_wb_stage_pkg.sv
// Shared types for the writeback stage: FSM states, load-size codes, alignment rule.
// Pure declarations; no latency or flow control of its own.
package lsu_wb_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RESP   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_t;

    function automatic logic ld_misaligned(input logic [1:0] size, input logic [2:0] offset);
        logic mis;
        case (size)
            LD_B:    mis = 1'b0;
            LD_H:    mis = offset[0];
            LD_W:    mis = (offset[1:0] != 2'd0);
            default: mis = (offset != 3'd0);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts a byte/half/word/dword field from a doubleword and sign/zero-extends it.
// Combinational (0 cycles); no flow control.
module load_align
    import lsu_wb_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            ld_unsigned,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    assign shifted = mem_rdata >> {offset, 3'b000};

    always_comb begin
        data = mem_rdata;
        case (size)
            LD_B:    data = {{(XLEN-8){~ld_unsigned & shifted[7]}},   shifted[7:0]};
            LD_H:    data = {{(XLEN-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
            LD_W:    data = {{(XLEN-32){~ld_unsigned & shifted[31]}}, shifted[31:0]};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_wb_stage.sv
// Writeback stage: ALU results commit 1 cycle after accept, loads 1 cycle after mem_rvalid.
// One instruction in flight; ex_ready high only in IDLE, request held until mem_req_ready.
module lsu_wb_stage
    import lsu_wb_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_rd,
    input  logic              ex_wen,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              ex_is_load,
    input  logic [1:0]        ex_ld_size,
    input  logic              ex_ld_unsigned,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [4:0]        rd,
    output logic [XLEN-1:0]   rd_wdata,
    output logic              reg_wen,
    output logic              retire,
    output logic              ld_misalign
);

    state_t            state, state_nxt;
    logic [4:0]        cap_rd;
    logic              cap_wen;
    logic [2:0]        cap_off;
    logic [1:0]        cap_size;
    logic              cap_uns;
    logic [XLEN-1:0]   align_data;
    logic              ex_mis;

    logic              ex_ready_nxt;
    logic              mem_req_valid_nxt;
    logic [ADDR_W-1:0] mem_req_addr_nxt;
    logic [4:0]        rd_nxt;
    logic [XLEN-1:0]   rd_wdata_nxt;
    logic              reg_wen_nxt;
    logic              retire_nxt;
    logic              ld_misalign_nxt;

    load_align #(.XLEN(XLEN)) u_align (
        .mem_rdata   (mem_rdata),
        .offset      (cap_off),
        .size        (cap_size),
        .ld_unsigned (cap_uns),
        .data        (align_data)
    );

    assign ex_mis = ex_is_load & ld_misaligned(ex_ld_size, ex_result[2:0]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are computed from the upcoming state so every port is a flop.
    always_comb begin
        state_nxt         = state;
        mem_req_valid_nxt = 1'b0;
        mem_req_addr_nxt  = mem_req_addr;
        rd_nxt            = 5'd0;
        rd_wdata_nxt      = '0;
        reg_wen_nxt       = 1'b0;
        retire_nxt        = 1'b0;
        ld_misalign_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load && !ex_mis) begin
                        state_nxt         = REQ;
                        mem_req_valid_nxt = 1'b1;
                        mem_req_addr_nxt  = {ex_result[ADDR_W-1:3], 3'b000};
                    end else begin
                        state_nxt       = COMMIT;
                        retire_nxt      = 1'b1;
                        rd_nxt          = ex_rd;
                        rd_wdata_nxt    = ex_mis ? '0 : ex_result;
                        reg_wen_nxt     = ex_wen && (ex_rd != 5'd0) && !ex_mis;
                        ld_misalign_nxt = ex_mis;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt = RESP;
                end else begin
                    mem_req_valid_nxt = 1'b1;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_nxt    = COMMIT;
                    retire_nxt   = 1'b1;
                    rd_nxt       = cap_rd;
                    rd_wdata_nxt = align_data;
                    reg_wen_nxt  = cap_wen && (cap_rd != 5'd0);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        ex_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            rd            <= 5'd0;
            rd_wdata      <= '0;
            reg_wen       <= 1'b0;
            retire        <= 1'b0;
            ld_misalign   <= 1'b0;
        end else begin
            ex_ready      <= ex_ready_nxt;
            mem_req_valid <= mem_req_valid_nxt;
            mem_req_addr  <= mem_req_addr_nxt;
            rd            <= rd_nxt;
            rd_wdata      <= rd_wdata_nxt;
            reg_wen       <= reg_wen_nxt;
            retire        <= retire_nxt;
            ld_misalign   <= ld_misalign_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_rd   <= 5'd0;
            cap_wen  <= 1'b0;
            cap_off  <= 3'd0;
            cap_size <= 2'd0;
            cap_uns  <= 1'b0;
        end else if (state == IDLE && ex_valid) begin
            cap_rd   <= ex_rd;
            cap_wen  <= ex_wen;
            cap_off  <= ex_result[2:0];
            cap_size <= ex_ld_size;
            cap_uns  <= ex_ld_unsigned;
        end
    end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Scoreboard bench for lsu_wb_stage: directed ALU/load/misalign/reset-abort vectors,
// expected commits queued at issue and checked by an independent retire monitor.
module tb_lsu_wb_stage;
    import lsu_wb_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic [63:0] ex_result;
    logic        ex_is_load;
    logic [1:0]  ex_ld_size;
    logic        ex_ld_unsigned;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic [4:0]  rd;
    logic [63:0] rd_wdata;
    logic        reg_wen;
    logic        retire;
    logic        ld_misalign;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic        wen;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    lsu_wb_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_rd          (ex_rd),
        .ex_wen         (ex_wen),
        .ex_result      (ex_result),
        .ex_is_load     (ex_is_load),
        .ex_ld_size     (ex_ld_size),
        .ex_ld_unsigned (ex_ld_unsigned),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rd             (rd),
        .rd_wdata       (rd_wdata),
        .reg_wen        (reg_wen),
        .retire         (retire),
        .ld_misalign    (ld_misalign)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Retire monitor: every commit must match the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (retire === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_retire", 64'(retire), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("reg_wen", 64'(reg_wen), 64'(e.wen));
                chk("ld_misalign", 64'(ld_misalign), 64'(e.mis));
                chk("rd_wdata", rd_wdata, e.wdata);
                if (e.wen) chk("rd", 64'(rd), 64'(e.rd));
            end
        end else if (reg_wen !== 1'b0) begin
            chk("reg_wen_without_retire", 64'(reg_wen), 64'd0);
        end
    end

    task automatic push_exp(input logic [4:0] r, input logic [63:0] wd, input logic w, input logic m);
        exp_t e;
        e.rd = r; e.wdata = wd; e.wen = w; e.mis = m;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [4:0] r, input logic w, input logic [63:0] res,
                         input logic ld, input logic [1:0] sz, input logic u);
        int t = 0;
        while (ex_ready !== 1'b1 && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        if (ex_ready !== 1'b1) chk("ex_ready_timeout", 64'(ex_ready), 64'd1);
        ex_rd = r; ex_wen = w; ex_result = res; ex_is_load = ld;
        ex_ld_size = sz; ex_ld_unsigned = u; ex_valid = 1'b1;
        @(posedge clock); #1;
        ex_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] r, input logic w, input logic [63:0] res);
        push_exp(r, res, w && (r != 5'd0), 1'b0);
        issue(r, w, res, 1'b0, LD_B, 1'b0);
    endtask

    // Stray mem_rvalid with garbage is driven during REQ; it must be ignored.
    task automatic load(input logic [4:0] r, input logic [63:0] addr, input logic [1:0] sz,
                        input logic u, input logic [63:0] data, input int req_wait,
                        input int rsp_wait, input logic [63:0] exp_wd, input logic [31:0] exp_addr);
        push_exp(r, exp_wd, r != 5'd0, 1'b0);
        issue(r, 1'b1, addr, 1'b1, sz, u);
        for (int i = 0; i < req_wait; i++) begin
            chk("req_valid_wait", 64'(mem_req_valid), 64'd1);
            chk("req_addr_wait", 64'(mem_req_addr), 64'(exp_addr));
            mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            @(posedge clock); #1;
            mem_rvalid = 1'b0; mem_rdata = '0;
        end
        chk("req_valid", 64'(mem_req_valid), 64'd1);
        chk("req_addr", 64'(mem_req_addr), 64'(exp_addr));
        mem_req_ready = 1'b1;
        @(posedge clock); #1;
        mem_req_ready = 1'b0;
        chk("req_valid_dropped", 64'(mem_req_valid), 64'd0);
        repeat (rsp_wait) begin @(posedge clock); #1; end
        mem_rvalid = 1'b1; mem_rdata = data;
        @(posedge clock); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_wen = 1'b0; ex_result = '0;
        ex_is_load = 1'b0; ex_ld_size = '0; ex_ld_unsigned = 1'b0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_rd_wdata", rd_wdata, 64'd0);
        chk("rst_reg_wen", 64'(reg_wen), 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        chk("rst_ld_misalign", 64'(ld_misalign), 64'd0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        alu(5'd5, 1'b1, 64'h1234);
        chk("ex_ready_low_commit", 64'(ex_ready), 64'd0);
        @(posedge clock); #1;
        chk("ex_ready_back", 64'(ex_ready), 64'd1);

        alu(5'd0, 1'b1, 64'hFF);
        alu(5'd7, 1'b0, 64'hABC);

        load(5'd3, 64'h8000_0003, LD_B, 1'b0, 64'h0000_0000_80FF_0000, 2, 3,
             64'hFFFF_FFFF_FFFF_FF80, 32'h8000_0000);
        load(5'd10, 64'h8000_0104, LD_W, 1'b1, 64'h89AB_CDEF_0000_0000, 0, 0,
             64'h0000_0000_89AB_CDEF, 32'h8000_0100);
        load(5'd11, 64'h1000_0002, LD_H, 1'b0, 64'h0000_0000_8001_0000, 1, 1,
             64'hFFFF_FFFF_FFFF_8001, 32'h1000_0000);
        load(5'd12, 64'h2000_0007, LD_B, 1'b1, 64'hF000_0000_0000_0000, 0, 2,
             64'h0000_0000_0000_00F0, 32'h2000_0000);
        load(5'd13, 64'h3000_0008, LD_D, 1'b0, 64'hDEAD_BEEF_0123_4567, 1, 0,
             64'hDEAD_BEEF_0123_4567, 32'h3000_0008);
        load(5'd9, 64'h4000_0010, LD_W, 1'b0, 64'h1111_1111_8000_0000, 0, 1,
             64'hFFFF_FFFF_8000_0000, 32'h4000_0010);

        push_exp(5'd4, 64'd0, 1'b0, 1'b1);
        issue(5'd4, 1'b1, 64'h4000_0001, 1'b1, LD_H, 1'b0);
        chk("mis_h_no_req", 64'(mem_req_valid), 64'd0);
        @(posedge clock); #1;
        chk("mis_h_no_req_after", 64'(mem_req_valid), 64'd0);

        push_exp(5'd14, 64'd0, 1'b0, 1'b1);
        issue(5'd14, 1'b1, 64'h4000_0004, 1'b1, LD_D, 1'b0);
        chk("mis_d_no_req", 64'(mem_req_valid), 64'd0);

        // Abort a load in RESP, then deliver its late response.
        issue(5'd6, 1'b1, 64'h5000_0000, 1'b1, LD_D, 1'b0);
        mem_req_ready = 1'b1;
        @(posedge clock); #1;
        mem_req_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort_ex_ready", 64'(ex_ready), 64'd1);
        chk("abort_req_valid", 64'(mem_req_valid), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        @(posedge clock); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_wen", 64'(reg_wen), 64'd0);
            chk("abort_no_retire", 64'(retire), 64'd0);
            chk("abort_idle_ready", 64'(ex_ready), 64'd1);
            @(posedge clock); #1;
        end

        alu(5'd8, 1'b1, 64'h55);

        repeat (3) begin @(posedge clock); #1; end
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
